// File: rtl/crc_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : crc_ctrl_if
//  Purpose  : Frame control, data stream, engine and result signals of crc_ctrl
//  Revision : 1.0  initial release
// ============================================================================
interface crc_ctrl_if;
  logic        start;
  logic        mode;
  logic [31:0] seed;
  logic        abort;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [31:0] eng_data;
  logic [31:0] eng_init;
  logic [3:0]  eng_select;
  logic [31:0] eng_crc;
  logic [31:0] res_crc;
  logic [15:0] res_count;
  logic        res_valid;
  logic        res_ready;
  logic        busy;

  modport slave (
    input  start, mode, seed, abort, s_data, s_valid, s_last, eng_crc, res_ready,
    output s_ready, eng_data, eng_init, eng_select, res_crc, res_count, res_valid, busy
  );

  modport master (
    output start, mode, seed, abort, s_data, s_valid, s_last, eng_crc, res_ready,
    input  s_ready, eng_data, eng_init, eng_select, res_crc, res_count, res_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/crc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : crc_ctrl
//  Purpose  : Frame controller feeding an external combinational CRC-16/32 engine
//  Revision : 1.0  initial release
// ============================================================================
module crc_ctrl #(
  parameter logic [31:0] XOR_OUT = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  crc_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_crc;
  logic        r_mode;
  logic [15:0] r_cnt;
  logic [31:0] r_res_crc;
  logic [15:0] r_res_count;

  logic        w_load;
  logic        w_beat;
  logic [15:0] w_cnt_inc;
  logic [31:0] w_eng_masked;
  logic [31:0] w_xor_masked;

  always_comb begin
    w_load       = 1'b0;
    w_beat       = 1'b0;
    w_cnt_inc    = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    // Upper half is meaningless in CRC-16 mode, so it never reaches state or result
    w_eng_masked = r_mode ? bus.eng_crc : {16'h0000, bus.eng_crc[15:0]};
    w_xor_masked = r_mode ? XOR_OUT     : {16'h0000, XOR_OUT[15:0]};
    w_next       = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          w_load = 1'b1;
          w_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          w_next = ST_IDLE;
        end else if (bus.s_valid) begin
          w_beat = 1'b1;
          if (bus.s_last) begin
            w_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (bus.abort || bus.res_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_crc       <= 32'h0;
      r_mode      <= 1'b0;
      r_cnt       <= 16'h0;
      r_res_crc   <= 32'h0;
      r_res_count <= 16'h0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_crc  <= bus.mode ? bus.seed : {16'h0000, bus.seed[15:0]};
        r_mode <= bus.mode;
        r_cnt  <= 16'h0;
      end
      if (w_beat) begin
        r_crc <= w_eng_masked;
        r_cnt <= w_cnt_inc;
        if (bus.s_last) begin
          r_res_crc   <= w_eng_masked ^ w_xor_masked;
          r_res_count <= w_cnt_inc;
        end
      end
    end
  end

  assign bus.s_ready    = (r_state == ST_RUN) && !bus.abort;
  assign bus.eng_data   = (r_state == ST_RUN) ? bus.s_data : 32'h0;
  assign bus.eng_init   = r_crc;
  assign bus.eng_select = r_mode ? 4'hF : 4'h0;
  assign bus.res_crc    = r_res_crc;
  assign bus.res_count  = r_res_count;
  assign bus.res_valid  = (r_state == ST_DONE);
  assign bus.busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_crc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_crc_ctrl
//  Purpose  : Directed self-checking bench for crc_ctrl with a frame-level model
//  Revision : 1.0  initial release
// ============================================================================
module tb_crc_ctrl;

  logic clk;
  logic rst;
  logic chk_en;
  int   n_chk;
  int   n_err;

  crc_ctrl_if bus ();

  crc_ctrl #(.XOR_OUT(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bit-serial MSB-first CRC; CRC-16 consumes only the low data half
  function automatic logic [31:0] crc_fn(input logic [31:0] c, input logic [31:0] d, input logic m);
    logic [31:0] r;
    logic [15:0] h;
    logic        fb;
    r = c;
    h = c[15:0];
    if (m) begin
      for (int i = 0; i < 32; i++) begin
        fb = r[31] ^ d[31-i];
        r  = {r[30:0], 1'b0};
        if (fb) r = r ^ 32'h04C1_1DB7;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        fb = h[15] ^ d[15-i];
        h  = {h[14:0], 1'b0};
        if (fb) h = h ^ 16'h8005;
      end
      r = {16'h0000, h};
    end
    return r;
  endfunction

  function automatic logic [31:0] msk(input logic [31:0] v, input logic m);
    return m ? v : {16'h0000, v[15:0]};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Engine stand-in
  always_comb bus.eng_crc = crc_fn(bus.eng_init, bus.eng_data, bus.eng_select == 4'hF);

  // Frame-level model: phase 0 = waiting, 1 = collecting words, 2 = holding result
  int          m_phase;
  logic [31:0] m_crc;
  logic        m_mode;
  logic [15:0] m_cnt;
  logic [31:0] m_res_crc;
  logic [15:0] m_res_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0; m_crc <= 32'h0; m_mode <= 1'b0; m_cnt <= 16'h0;
      m_res_crc <= 32'h0; m_res_cnt <= 16'h0;
    end else if (m_phase == 0) begin
      if (bus.start && !bus.abort) begin
        m_phase <= 1;
        m_crc   <= msk(bus.seed, bus.mode);
        m_mode  <= bus.mode;
        m_cnt   <= 16'h0;
      end
    end else if (m_phase == 1) begin
      if (bus.abort) begin
        m_phase <= 0;
      end else if (bus.s_valid) begin
        m_crc <= msk(crc_fn(m_crc, bus.s_data, m_mode), m_mode);
        m_cnt <= sat_inc(m_cnt);
        if (bus.s_last) begin
          m_phase   <= 2;
          m_res_crc <= msk(crc_fn(m_crc, bus.s_data, m_mode), m_mode);
          m_res_cnt <= sat_inc(m_cnt);
        end
      end
    end else begin
      if (bus.abort || bus.res_ready) m_phase <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_ready",    32'(bus.s_ready),    32'(m_phase == 1 && !bus.abort));
      chk("eng_data",   bus.eng_data,        (m_phase == 1) ? bus.s_data : 32'h0);
      chk("eng_init",   bus.eng_init,        m_crc);
      chk("eng_select", 32'(bus.eng_select), m_mode ? 32'hF : 32'h0);
      chk("res_valid",  32'(bus.res_valid),  32'(m_phase == 2));
      chk("busy",       32'(bus.busy),       32'(m_phase != 0));
      chk("res_crc",    bus.res_crc,         m_res_crc);
      chk("res_count",  32'(bus.res_count),  32'(m_res_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic m, input logic [31:0] sd);
    bus.start = 1'b1; bus.mode = m; bus.seed = sd;
    tick();
    bus.start = 1'b0; bus.mode = 1'b0; bus.seed = 32'h0;
  endtask

  // Gap cycles carry s_last without s_valid, which must be ignored
  task automatic send(input logic [31:0] d, input logic last, input int gap);
    for (int g = 0; g < gap; g++) begin
      bus.s_last = 1'b1;
      tick();
    end
    bus.s_valid = 1'b1; bus.s_data = d; bus.s_last = last;
    tick();
    bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_data = 32'h5A5A_A5A5;
  endtask

  task automatic consume();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_err = 0; chk_en = 1'b0;
    rst = 1'b1;
    bus.start = 1'b0; bus.mode = 1'b0; bus.seed = 32'h0; bus.abort = 1'b0;
    bus.s_data = 32'h0; bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.res_ready = 1'b0;
    repeat (3) tick();
    chk("rst_busy",   32'(bus.busy), 32'h0);
    chk("rst_select", 32'(bus.eng_select), 32'h0);
    chk("rst_init",   bus.eng_init, 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    // CRC-32 single word
    start_frame(1'b1, 32'h0000_0001);
    send(32'h0, 1'b1, 0);
    chk("c32_valid", 32'(bus.res_valid), 32'h1);
    chk("c32_crc",   bus.res_crc, 32'h04C1_1DB7);
    chk("c32_count", 32'(bus.res_count), 32'h1);
    consume();

    // CRC-16 seed upper half dropped
    start_frame(1'b0, 32'hFFFF_0001);
    chk("c16_init", bus.eng_init, 32'h0000_0001);
    send(32'h0, 1'b1, 0);
    chk("c16_crc", bus.res_crc, 32'h0000_8005);
    consume();

    // Four zero words with gaps
    start_frame(1'b1, 32'h0);
    for (int i = 0; i < 4; i++) send(32'h0, i == 3, 2);
    chk("gap_crc",   bus.res_crc, 32'h0);
    chk("gap_count", 32'(bus.res_count), 32'h4);
    consume();

    // Non-trivial data, both modes
    start_frame(1'b1, 32'hFFFF_FFFF);
    send(32'h1234_5678, 1'b0, 1);
    send(32'hDEAD_BEEF, 1'b0, 0);
    send(32'h0000_00FF, 1'b1, 3);
    consume();
    start_frame(1'b0, 32'hABCD_1234);
    send(32'h1234_5678, 1'b0, 0);
    send(32'hDEAD_BEEF, 1'b1, 1);
    consume();

    // Result held with res_ready low and start pulsed
    start_frame(1'b1, 32'h0000_0001);
    send(32'h0, 1'b1, 0);
    for (int i = 0; i < 5; i++) begin
      bus.start = (i % 2) == 0; bus.seed = 32'h1111_1111; bus.mode = 1'b1;
      tick();
    end
    chk("hold_valid",  32'(bus.res_valid), 32'h1);
    chk("hold_ready",  32'(bus.s_ready), 32'h0);
    chk("hold_crc",    bus.res_crc, 32'h04C1_1DB7);
    bus.start = 1'b1;
    consume();
    bus.start = 1'b0;
    chk("hs_start_ignored", 32'(bus.busy), 32'h0);

    // Abort after two beats, then a fresh frame
    start_frame(1'b1, 32'h0000_0007);
    send(32'h0000_0003, 1'b0, 0);
    send(32'h0000_0004, 1'b0, 0);
    bus.abort = 1'b1; bus.s_valid = 1'b1; bus.s_last = 1'b1;
    tick();
    bus.abort = 1'b0; bus.s_valid = 1'b0; bus.s_last = 1'b0;
    chk("abort_busy",  32'(bus.busy), 32'h0);
    chk("abort_valid", 32'(bus.res_valid), 32'h0);
    start_frame(1'b1, 32'h0000_0001);
    send(32'h0, 1'b1, 0);
    chk("abort_next_crc",   bus.res_crc, 32'h04C1_1DB7);
    chk("abort_next_count", 32'(bus.res_count), 32'h1);

    // Abort in DONE beats a coincident handshake
    bus.abort = 1'b1; bus.res_ready = 1'b1;
    tick();
    bus.abort = 1'b0; bus.res_ready = 1'b0;
    chk("abort_done_busy", 32'(bus.busy), 32'h0);

    // Abort in IDLE suppresses start
    bus.abort = 1'b1; bus.start = 1'b1; bus.mode = 1'b1; bus.seed = 32'h5;
    tick();
    bus.abort = 1'b0; bus.start = 1'b0;
    chk("idle_abort_busy", 32'(bus.busy), 32'h0);
    tick();

    // Reset mid-frame with a valid word
    start_frame(1'b1, 32'hCAFE_F00D);
    send(32'h0000_0042, 1'b0, 0);
    rst = 1'b1; bus.s_valid = 1'b1; bus.s_last = 1'b1; bus.start = 1'b1;
    tick();
    rst = 1'b0; bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.start = 1'b0;
    chk("mrst_busy",  32'(bus.busy), 32'h0);
    chk("mrst_init",  bus.eng_init, 32'h0);
    chk("mrst_crc",   bus.res_crc, 32'h0);
    chk("mrst_valid", 32'(bus.res_valid), 32'h0);
    tick();

    // Word count saturation
    start_frame(1'b1, 32'h0);
    bus.s_valid = 1'b1; bus.s_data = 32'h0;
    for (int i = 0; i < 65540; i++) begin
      bus.s_last = (i == 65539);
      tick();
    end
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
    chk("sat_count", 32'(bus.res_count), 32'h0000_FFFF);
    consume();
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
